// File: rtl/simple_datapath.sv
// Execution stage: instruction register, 8-entry register file, B-shifter, ALU,
// result register C and Z/N/V status flags, all steered by the controller FSM.
module simple_datapath #(
  parameter int DW    = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instr_in,
  input  logic          load_ir,
  input  logic [DW-1:0] mdata,
  input  logic [1:0]    vsel,
  input  logic [2:0]    nsel,
  input  logic          loada,
  input  logic          loadb,
  input  logic          loadc,
  input  logic          loads,
  input  logic          asel,
  input  logic          bsel,
  input  logic          write,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [DW-1:0] datapath_out,
  output logic          Z,
  output logic          N,
  output logic          V
);

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext5(input logic [4:0] v);
    return {{(DW-5){v[4]}}, v};
  endfunction

  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic          r_z;
  logic          r_n;
  logic          r_v;
  logic [DW-1:0] r_rf [0:NREGS-1];

  logic [2:0]    w_idx;
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_bsh;
  logic [DW-1:0] w_ain;
  logic [DW-1:0] w_bin;
  logic [DW-1:0] w_alu;
  logic          w_ovf;
  logic [1:0]    w_shift;

  assign opcode       = r_ir[15:13];
  assign op           = r_ir[12:11];
  assign w_shift      = r_ir[4:3];
  assign datapath_out = r_c;
  assign Z            = r_z;
  assign N            = r_n;
  assign V            = r_v;

  // Register index: Rm over Rd over Rn, index 0 when nothing is selected.
  always_comb begin
    w_idx = 3'd0;
    if (nsel[2]) begin
      w_idx = r_ir[2:0];
    end else if (nsel[1]) begin
      w_idx = r_ir[7:5];
    end else if (nsel[0]) begin
      w_idx = r_ir[10:8];
    end else begin
      w_idx = 3'd0;
    end
  end

  assign w_rdata = r_rf[w_idx];

  // Write-back source mux.
  always_comb begin
    w_wdata = r_c;
    case (vsel)
      2'b00:   w_wdata = r_c;
      2'b01:   w_wdata = mdata;
      2'b10:   w_wdata = sext8(r_ir[7:0]);
      2'b11:   w_wdata = {DW{1'b0}};
      default: w_wdata = {DW{1'b0}};
    endcase
  end

  // Single-bit shifter applied to the B operand.
  always_comb begin
    w_bsh = r_b;
    case (w_shift)
      2'b00:   w_bsh = r_b;
      2'b01:   w_bsh = {r_b[DW-2:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[DW-1:1]};
      2'b11:   w_bsh = {r_b[DW-1], r_b[DW-1:1]};
      default: w_bsh = r_b;
    endcase
  end

  assign w_ain = asel ? {DW{1'b0}} : r_a;
  assign w_bin = bsel ? sext5(r_ir[4:0]) : w_bsh;

  // ALU; overflow only meaningful for add/subtract.
  always_comb begin
    w_alu = {DW{1'b0}};
    w_ovf = 1'b0;
    case (op)
      2'b00: begin
        w_alu = w_ain + w_bin;
        w_ovf = (w_ain[DW-1] == w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
      end
      2'b01: begin
        w_alu = w_ain - w_bin;
        w_ovf = (w_ain[DW-1] != w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
      end
      2'b10: begin
        w_alu = w_ain & w_bin;
        w_ovf = 1'b0;
      end
      2'b11: begin
        w_alu = ~w_bin;
        w_ovf = 1'b0;
      end
      default: begin
        w_alu = {DW{1'b0}};
        w_ovf = 1'b0;
      end
    endcase
  end

  // Register file; reads are combinational so a same-edge load sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= {DW{1'b0}};
      end
    end else if (write) begin
      r_rf[w_idx] <= w_wdata;
    end
  end

  // Instruction, operand and result registers plus status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= {DW{1'b0}};
      r_a  <= {DW{1'b0}};
      r_b  <= {DW{1'b0}};
      r_c  <= {DW{1'b0}};
      r_z  <= 1'b0;
      r_n  <= 1'b0;
      r_v  <= 1'b0;
    end else begin
      if (load_ir) r_ir <= instr_in;
      if (loada)   r_a  <= w_rdata;
      if (loadb)   r_b  <= w_rdata;
      if (loadc)   r_c  <= w_alu;
      if (loads) begin
        r_z <= (w_alu == {DW{1'b0}});
        r_n <= w_alu[DW-1];
        r_v <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_simple_datapath.sv
// Directed scenarios plus a randomized run checked against an arithmetic model.
module tb_simple_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        load_ir;
  logic [15:0] mdata;
  logic [1:0]  vsel;
  logic [2:0]  nsel;
  logic        loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [15:0] datapath_out;
  logic        Z, N, V;

  int n_pass = 0;
  int n_total = 0;

  simple_datapath dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .load_ir(load_ir),
    .mdata(mdata), .vsel(vsel), .nsel(nsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write),
    .opcode(opcode), .op(op), .datapath_out(datapath_out), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    load_ir = 1'b0; vsel = 2'b00; nsel = 3'b000; write = 1'b0;
    loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
    asel = 1'b0; bsel = 1'b0;
  endtask

  task automatic load_instr(input logic [15:0] ins);
    clear_ctrl();
    instr_in = ins; load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] k, input logic [15:0] val);
    load_instr({3'b110, 2'b10, k, 8'h00});
    nsel = 3'b001; vsel = 2'b01; mdata = val; write = 1'b1;
    tick();
    clear_ctrl();
  endtask

  // Reads R[k] through A and the adder (A + sximm5 of zero); clobbers IR, A and C.
  task automatic read_reg(input logic [2:0] k, output logic [15:0] val);
    load_instr({3'b101, 2'b00, k, 8'h00});
    nsel = 3'b001; loada = 1'b1;
    tick();
    clear_ctrl();
    bsel = 1'b1; loadc = 1'b1;
    tick();
    clear_ctrl();
    val = datapath_out;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0;
    clear_ctrl(); instr_in = 16'h0000; mdata = 16'h0000;
    tick(); tick();
    n_total++;
    if ({opcode, op, datapath_out, Z, N, V} !== 24'h0) begin
      $display("FAIL reset_state: got %h %h %h %b%b%b want all zero", opcode, op, datapath_out, Z, N, V);
    end else n_pass++;
    reset = 1'b1;
    tick();
    wr_reg(3'd3, 16'h1234);
    read_reg(3'd3, v);
    n_total++;
    if (v !== 16'h1234) $display("FAIL reset_pre_r3: got %h want 1234", v);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({opcode, op, datapath_out, Z, N, V} !== 24'h0) begin
      $display("FAIL reset_async: got %h %h %h %b%b%b want all zero", opcode, op, datapath_out, Z, N, V);
    end else n_pass++;
    #1 reset = 1'b1;
    read_reg(3'd3, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL reset_r3_cleared: got %h want 0000", v);
    else n_pass++;
  endtask

  task automatic test_mov();
    logic [15:0] v;
    load_instr(16'hD007);
    n_total++;
    if ({opcode, op} !== 5'b110_10) $display("FAIL mov_decode: got %b %b want 110 10", opcode, op);
    else n_pass++;
    nsel = 3'b001; vsel = 2'b10; write = 1'b1;
    tick();
    clear_ctrl();
    read_reg(3'd0, v);
    n_total++;
    if (v !== 16'h0007) $display("FAIL mov_r0: got %h want 0007", v);
    else n_pass++;
    load_instr(16'hD180);
    nsel = 3'b001; vsel = 2'b10; write = 1'b1;
    tick();
    clear_ctrl();
    read_reg(3'd1, v);
    n_total++;
    if (v !== 16'hFF80) $display("FAIL mov_sext: got %h want ff80", v);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [15:0] v;
    wr_reg(3'd1, 16'h0002);
    wr_reg(3'd0, 16'h0007);
    load_instr(16'hA148);
    nsel = 3'b100; loadb = 1'b1; tick(); clear_ctrl();
    nsel = 3'b001; loada = 1'b1; tick(); clear_ctrl();
    loadc = 1'b1; tick(); clear_ctrl();
    nsel = 3'b010; vsel = 2'b00; write = 1'b1; tick(); clear_ctrl();
    n_total++;
    if (datapath_out !== 16'h0010) $display("FAIL add_c: got %h want 0010", datapath_out);
    else n_pass++;
    read_reg(3'd2, v);
    n_total++;
    if (v !== 16'h0010) $display("FAIL add_r2: got %h want 0010", v);
    else n_pass++;
  endtask

  task automatic test_cmp();
    logic [15:0] c_before;
    wr_reg(3'd0, 16'h8000);
    wr_reg(3'd1, 16'h0001);
    wr_reg(3'd2, 16'h4321);
    // Known C value via a read, so its preservation is checked against a constant.
    read_reg(3'd2, c_before);
    load_instr(16'hA801);
    nsel = 3'b001; loada = 1'b1; tick(); clear_ctrl();
    nsel = 3'b100; loadb = 1'b1; tick(); clear_ctrl();
    loads = 1'b1; tick(); clear_ctrl();
    n_total++;
    if ({V, N, Z} !== 3'b100) $display("FAIL cmp_ovf_flags: got VNZ=%b%b%b want 100", V, N, Z);
    else n_pass++;
    n_total++;
    if (datapath_out !== 16'h4321) $display("FAIL cmp_c_held: got %h want 4321", datapath_out);
    else n_pass++;
    wr_reg(3'd0, 16'h0005);
    wr_reg(3'd1, 16'h0005);
    load_instr(16'hA801);
    nsel = 3'b001; loada = 1'b1; tick(); clear_ctrl();
    nsel = 3'b100; loadb = 1'b1; tick(); clear_ctrl();
    loads = 1'b1; tick(); clear_ctrl();
    n_total++;
    if ({Z, V} !== 2'b10) $display("FAIL cmp_equal_flags: got ZV=%b%b want 10", Z, V);
    else n_pass++;
  endtask

  task automatic test_mvn_and();
    wr_reg(3'd1, 16'h00F0);
    load_instr(16'hB801);
    nsel = 3'b100; loadb = 1'b1; tick(); clear_ctrl();
    asel = 1'b1; loadc = 1'b1; loads = 1'b1; tick(); clear_ctrl();
    n_total++;
    if ({datapath_out, N} !== {16'hFF0F, 1'b1}) $display("FAIL mvn: got C=%h N=%b want ff0f 1", datapath_out, N);
    else n_pass++;
    wr_reg(3'd0, 16'h0FF0);
    wr_reg(3'd1, 16'h00FF);
    load_instr(16'hB001);
    nsel = 3'b001; loada = 1'b1; tick(); clear_ctrl();
    nsel = 3'b100; loadb = 1'b1; tick(); clear_ctrl();
    loadc = 1'b1; loads = 1'b1; tick(); clear_ctrl();
    n_total++;
    if ({datapath_out, V, N, Z} !== {16'h00F0, 3'b000}) begin
      $display("FAIL and: got C=%h VNZ=%b%b%b want 00f0 000", datapath_out, V, N, Z);
    end else n_pass++;
  endtask

  task automatic test_hazard();
    wr_reg(3'd4, 16'h0011);
    // IR 0xD455: Rn=4, sximm8=0x55, op=AND, sximm5=0xFFF5 (transparent for both probe values).
    load_instr(16'hD455);
    nsel = 3'b001; vsel = 2'b10; write = 1'b1; loada = 1'b1; tick(); clear_ctrl();
    bsel = 1'b1; loadc = 1'b1; tick(); clear_ctrl();
    n_total++;
    if (datapath_out !== 16'h0011) $display("FAIL hazard_old: got %h want 0011", datapath_out);
    else n_pass++;
    nsel = 3'b001; loada = 1'b1; tick(); clear_ctrl();
    bsel = 1'b1; loadc = 1'b1; tick(); clear_ctrl();
    n_total++;
    if (datapath_out !== 16'h0055) $display("FAIL hazard_new: got %h want 0055", datapath_out);
    else n_pass++;
  endtask

  // Behavioural reference state.
  logic [15:0] m_r [8];
  logic [15:0] m_ir, m_a, m_b, m_c;
  logic        m_z, m_n, m_v;

  task automatic model_edge();
    int ir, b, bs, sx5, sx8, ain, bin, sa, sb, sr, res, idx, rd, wb;
    logic ovf;
    ir = int'(m_ir);
    if (nsel[2])      idx = ir % 8;
    else if (nsel[1]) idx = (ir / 32) % 8;
    else if (nsel[0]) idx = (ir / 256) % 8;
    else              idx = 0;
    rd  = int'(m_r[idx]);
    sx5 = ir % 32;  if (sx5 >= 16)  sx5 += 65536 - 32;
    sx8 = ir % 256; if (sx8 >= 128) sx8 += 65536 - 256;
    b = int'(m_b);
    case ((ir / 8) % 4)
      0:       bs = b;
      1:       bs = (b * 2) % 65536;
      2:       bs = b / 2;
      default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
    ain = asel ? 0 : int'(m_a);
    bin = bsel ? sx5 : bs;
    sa = (ain >= 32768) ? ain - 65536 : ain;
    sb = (bin >= 32768) ? bin - 65536 : bin;
    ovf = 1'b0;
    case ((ir / 2048) % 4)
      0: begin res = (ain + bin) % 65536; sr = sa + sb; ovf = (sr > 32767) || (sr < -32768); end
      1: begin res = (ain - bin + 65536) % 65536; sr = sa - sb; ovf = (sr > 32767) || (sr < -32768); end
      2: res = ain & bin;
      default: res = 65535 - bin;
    endcase
    case (vsel)
      2'b00:   wb = int'(m_c);
      2'b01:   wb = int'(mdata);
      2'b10:   wb = sx8;
      default: wb = 0;
    endcase
    if (write)   m_r[idx] = wb[15:0];
    if (loada)   m_a = rd[15:0];
    if (loadb)   m_b = rd[15:0];
    if (loadc)   m_c = res[15:0];
    if (loads) begin m_z = (res == 0); m_n = (res >= 32768); m_v = ovf; end
    if (load_ir) m_ir = instr_in;
  endtask

  task automatic test_random();
    reset = 1'b0;
    clear_ctrl();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_ir = 16'h0; m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    tick();
    reset = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      instr_in = 16'($urandom);
      mdata    = 16'($urandom);
      load_ir  = ($urandom_range(0, 3) == 0);
      vsel     = 2'($urandom_range(0, 3));
      nsel     = 3'($urandom_range(0, 7));
      write    = ($urandom_range(0, 2) == 0);
      loada    = $urandom_range(0, 1) == 1;
      loadb    = $urandom_range(0, 1) == 1;
      loadc    = $urandom_range(0, 1) == 1;
      loads    = $urandom_range(0, 1) == 1;
      asel     = ($urandom_range(0, 3) == 0);
      bsel     = ($urandom_range(0, 3) == 0);
      model_edge();
      tick();
      n_total++;
      if ({opcode, op, datapath_out, Z, N, V} !== {m_ir[15:11], m_c, m_z, m_n, m_v}) begin
        $display("FAIL random_cycle%0d: got %b %b %h %b%b%b want %b %b %h %b%b%b", cyc,
                 opcode, op, datapath_out, Z, N, V, m_ir[15:13], m_ir[12:11], m_c, m_z, m_n, m_v);
      end else n_pass++;
    end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add();
    test_cmp();
    test_mvn_and();
    test_hazard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- Execution stage driven directly by `controller_fsm`.
- Holds the instruction register and decodes `opcode`/`op` back to the FSM.
- Consumes the FSM control word (`vsel`, `nsel`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `write`) to run the register file, shifter, ALU and status flags.
- Produces the result register C and the Z/N/V flags.

Parameters:
- DW, 16, datapath and instruction width (fixed 16; other values unsupported).
- NREGS, 8, register-file depth (3-bit register index).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. The codebase name `reset` is kept; the polarity is low-true.
- instr_in  input  16  instruction word to capture.
- load_ir  input  1  IR <= instr_in on the clock edge.
- mdata  input  16  external write-back value (vsel=01).
- vsel  input  2  write-back source select.
- nsel  input  3  one-hot register-index select: [2]=Rm, [1]=Rd, [0]=Rn.
- loada, loadb, loadc, loads  input  1 each  register/status enables.
- asel, bsel  input  1 each  ALU operand selects.
- write  input  1  register-file write enable.
- opcode  output  3  IR[15:13], to the FSM.
- op  output  2  IR[12:11], to the FSM.
- datapath_out  output  16  contents of C.
- Z, N, V  output  1 each  status flags.

Behaviour:
- Reset (reset=0, asynchronous):
  - IR, R0..R7, A, B, C, Z, N and V all clear to 0.
  - opcode=000, op=00, datapath_out=0x0000.
  - Takes effect immediately mid-operation, with no clock needed.
  - Loads resume on the first rising edge after reset returns high.
- IR fields:
  - opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], shift=[4:3], Rm=[2:0].
  - sximm8 = sign-extend IR[7:0].
  - sximm5 = sign-extend IR[4:0].
- opcode and op are combinational from IR. They are valid the cycle after load_ir, which is when the FSM samples them with s=1.
- Register index: nsel priority [2]>[1]>[0] selects Rm/Rd/Rn; nsel=000 selects index 0. The same index is used for the read and the write.
- Register-file read is combinational.
- Register-file write happens on the clock edge when write=1.
- Write-back data by vsel:
  - 00: C.
  - 01: mdata.
  - 10: sximm8.
  - 11: 0x0000.
- A and B:
  - A <= R[index] on the edge when loada=1.
  - B <= R[index] on the edge when loadb=1.
  - A write and a load of the same register in the same cycle: A/B capture the OLD value; the new value is visible from the next cycle.
- Shifter on B, by the shift field:
  - 00: pass.
  - 01: LSL1, LSB filled with 0.
  - 10: LSR1, MSB filled with 0.
  - 11: ASR1, MSB replicated.
- Operands:
  - Ain = asel ? 0x0000 : A.
  - Bin = bsel ? sximm5 : shifted B.
- ALU operation by the op field:
  - 00: Ain+Bin.
  - 01: Ain-Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
  - All results are 16-bit, with wrap-around (no carry out).
- C <= ALU result on the edge when loadc=1.
- Status flags update on the edge when loads=1:
  - Z = (result==0).
  - N = result[15].
  - V = signed overflow for op 00/01; V = 0 for op 10/11.
  - Flags hold otherwise.
- Enables are independent and may assert in the same cycle. loadc and loads in the same cycle both capture the same ALU result.
- End-to-end latency with FSM-issued control words:
  - MOV immediate: 1 cycle after decode.
  - Register ops: Rd is written 3–4 cycles after s, per the FSM sequence.
- Unused enables hold their registers; no register changes without its enable.

Test Plan:
- Reset mid-operation: load R3=0x1234, then drive reset=0 between edges → all outputs read 0 immediately, and R3 reads 0 after reset is released.
- MOV R0,#7:
  - Stimulus: instr_in=0xD007, load_ir; next cycle nsel=001, vsel=10, write=1.
  - Required: opcode=110, op=10, R0=0x0007.
  - Also instr 0xD180 → R1=0xFF80, checking sign extension.
- ADD R2,R1,R0 LSL#1:
  - Setup: R1=2, R0=7, IR=0xA148.
  - Sequence: nsel=100+loadb; nsel=001+loada; loadc; nsel=010+write.
  - Required: datapath_out=0x0010, R2=0x0010.
- CMP overflow:
  - Setup: A=0x8000, B=0x0001, op=01, shift 00.
  - Required: loads → V=1, N=0, Z=0; C is unchanged because loadc=0.
  - Then A=B=0x0005 → Z=1, V=0.
- MVN/AND:
  - B=0x00F0, asel=1, op=11 → C=0xFF0F, N=1.
  - A=0x0FF0, B=0x00FF, op=10 → C=0x00F0, V=0.
- Same-cycle hazard:
  - Stimulus: write R4=0x0055 and loada on index 4 in the same cycle, with old R4=0x0011.
  - Required: A=0x0011; a repeated loada next cycle gives A=0x0055.
